// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/response bundle between a requesting datapath (master) and the
// bit-serial adder controller (slave).
//
// Parameters:
//   WIDTH     operand/result width in bits (2..64)
// Signals:
//   start     request strobe (master -> slave)
//   a, b      operands, captured on an accepted start (master -> slave)
//   sub       subtract select, only when SERIAL_SUB_EN is defined
//   busy      high while the serial operation runs (slave -> master)
//   done      one-cycle completion pulse (slave -> master)
//   sum       registered result, held until the next completion
//   cout      final carry out of bit WIDTH-1
//   overflow  two's-complement overflow of the result
//
// Optional feature macro: SERIAL_SUB_EN (adds the sub signal).
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    output start, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
`ifdef SERIAL_SUB_EN
    input  sub,
`endif
    input  start, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller. On an accepted start the two operands are
// loaded into right-shift registers and a single 1-bit full-adder slice is
// stepped once per clock from LSB to MSB, with the carry held in a flop
// between iterations. The result is published together with a one-cycle
// done pulse; sum/cout/overflow only ever change on the final RUN edge.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   serial_add_ctrl_if.slave (start, a, b, [sub], busy, done, sum,
//         cout, overflow)
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   : bus.sub=1 loads ~b and a carry-in of 1, giving a-b
//               (cout=1 means no borrow)
//   undefined : add only, carry-in 0
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] op_a_q,     op_a_d;
  logic [WIDTH-1:0] op_b_q,     op_b_d;
  logic [WIDTH-1:0] res_q,      res_d;
  logic             carry_q,    carry_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;

  // The shared full-adder slice: always looks at the current LSBs and carry.
  logic fa_s;
  logic fa_c;

  assign fa_s = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign fa_c = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
`ifdef SERIAL_SUB_EN
          // a - b == a + ~b + 1: invert B and seed the carry with 1.
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
`else
          op_b_d  = bus.b;
          carry_d = 1'b0;
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last slice: carry_q is the carry into the MSB, fa_c the carry out.
          sum_d      = {fa_s, res_q[WIDTH-1:1]};
          cout_d     = fa_c;
          overflow_d = fa_c ^ carry_q;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge; blocking would chain the shift registers.
    if (rst) begin
      // NOTE: the operand/result shift registers are plain flops, not a RAM,
      // so they are reset along with the control state.
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;

endmodule
